// File: rtl/lbp_pkg.sv
// Shared types and constants for the LBP window fetcher: image defaults,
// fetch FSM states, 3x3 window pixel indices and the window bus packer.
package lbp_pkg;

  localparam int DEF_IMG_W  = 128;
  localparam int DEF_IMG_H  = 128;
  localparam int DEF_ADDR_W = 14;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_DONE
  } fetch_state_e;

  localparam int WIN_NPIX = 9;
  localparam int WIN_TL   = 0;
  localparam int WIN_TC   = 1;
  localparam int WIN_TR   = 2;
  localparam int WIN_ML   = 3;
  localparam int WIN_CTR  = 4;
  localparam int WIN_MR   = 5;
  localparam int WIN_BL   = 6;
  localparam int WIN_BC   = 7;
  localparam int WIN_BR   = 8;

  // Pixel k lands in bits [8k+7:8k].
  function automatic logic [71:0] pack_window(input logic [7:0] px [WIN_NPIX]);
    logic [71:0] bus;
    bus = '0;
    for (int k = 0; k < WIN_NPIX; k++) begin
      bus[8*k +: 8] = px[k];
    end
    return bus;
  endfunction

endpackage

// File: rtl/lbp_line_buffer.sv
// One image row of 8-bit pixels: combinational read of a column and a
// write of the same column at the clock edge (read sees the old value).
module lbp_line_buffer
  import lbp_pkg::*;
#(
  parameter int DEPTH = DEF_IMG_W,
  parameter int IDX_W = $clog2(DEF_IMG_W)
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] col,
  input  logic             wr_en,
  input  logic [7:0]       wr_data,
  output logic [7:0]       rd_data
);

  logic [7:0] mem [DEPTH];

  assign rd_data = mem[col];

  always_ff @(posedge clk) begin
    if (wr_en) mem[col] <= wr_data;
  end

endmodule

// File: rtl/lbp_window_fetch.sv
// Raster fetcher and 3x3 window generator feeding the LBP element.
// Optional LBP_FETCH_PERF_EN adds a saturating stall_cnt output.
//
// state    | meaning
// ST_IDLE  | waiting for gray_ready
// ST_FETCH | issuing one gray read per cycle unless stalled
// ST_DRAIN | all reads issued, emptying pipeline until last window accepted
// ST_DONE  | frame complete, held until reset
module lbp_window_fetch
  import lbp_pkg::*;
#(
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              gray_ready,
  output logic              gray_req,
  output logic [ADDR_W-1:0] gray_addr,
  input  logic [7:0]        gray_data,
  output logic              win_valid,
  input  logic              win_ready,
  output logic [71:0]       win_data,
  output logic [ADDR_W-1:0] win_addr,
`ifdef LBP_FETCH_PERF_EN
  output logic [15:0]       stall_cnt,
`endif
  output logic              done
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(IMG_W*IMG_H - 1);
  localparam logic [ADDR_W-1:0] LAST_CTR = ADDR_W'((IMG_H-2)*IMG_W + IMG_W - 2);
  localparam logic [ADDR_W-1:0] CTR_OFS  = ADDR_W'(IMG_W + 1);

  fetch_state_e state_q, state_d;

  logic             stall, issue, proc, win_hit;
  logic             inflight_q, skid_valid_q;
  logic [7:0]       skid_data_q, src_data, l1_rd, l2_rd;
  logic             src_valid;
  logic [ROW_W-1:0] row_q;
  logic [COL_W-1:0] col_q;
  logic [7:0]       col_a_q [3];
  logic [7:0]       col_b_q [3];
  logic [7:0]       px [WIN_NPIX];

  assign stall     = win_valid && !win_ready;
  assign issue     = (state_q == ST_FETCH) && gray_ready && !stall;
  assign src_valid = skid_valid_q || inflight_q;
  assign src_data  = skid_valid_q ? skid_data_q : gray_data;
  assign proc      = src_valid && !stall;
  assign win_hit   = (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    gray_req = 1'b0;
    done     = 1'b0;
    case (state_q)
      ST_IDLE:  if (gray_ready) state_d = ST_FETCH;
      ST_FETCH: begin
        gray_req = issue;
        if (issue && gray_addr == LAST_PIX) state_d = ST_DRAIN;
      end
      ST_DRAIN: if (win_valid && win_ready && win_addr == LAST_CTR) state_d = ST_DONE;
      ST_DONE:  done = 1'b1;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Window columns: a = col c-2, b = col c-1, incoming column comes from L2/L1/pixel.
  always_comb begin
    px[WIN_TL]  = col_a_q[0];
    px[WIN_TC]  = col_b_q[0];
    px[WIN_TR]  = l2_rd;
    px[WIN_ML]  = col_a_q[1];
    px[WIN_CTR] = col_b_q[1];
    px[WIN_MR]  = l1_rd;
    px[WIN_BL]  = col_a_q[2];
    px[WIN_BC]  = col_b_q[2];
    px[WIN_BR]  = src_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gray_addr    <= '0;
      inflight_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      row_q        <= '0;
      col_q        <= '0;
      col_a_q      <= '{default: '0};
      col_b_q      <= '{default: '0};
      win_valid    <= 1'b0;
      win_data     <= '0;
      win_addr     <= '0;
    end else begin
      inflight_q <= issue;
      if (issue) gray_addr <= gray_addr + 1'b1;

      // The one pixel already requested when a stall appears parks here.
      if (inflight_q && stall) begin
        skid_valid_q <= 1'b1;
        skid_data_q  <= gray_data;
      end else if (proc) begin
        skid_valid_q <= 1'b0;
      end

      if (proc) begin
        col_a_q <= col_b_q;
        col_b_q <= '{l2_rd, l1_rd, src_data};
        col_q   <= col_q + 1'b1;
        if (col_q == COL_W'(IMG_W - 1)) row_q <= row_q + 1'b1;
        win_valid <= win_hit;
        if (win_hit) begin
          win_data <= pack_window(px);
          win_addr <= ADDR_W'({row_q, col_q}) - CTR_OFS;
        end
      end else if (win_valid && win_ready) begin
        win_valid <= 1'b0;
      end
    end
  end

  lbp_line_buffer #(.DEPTH(IMG_W), .IDX_W(COL_W)) u_l1 (
    .clk     (clk),
    .col     (col_q),
    .wr_en   (proc),
    .wr_data (src_data),
    .rd_data (l1_rd)
  );

  lbp_line_buffer #(.DEPTH(IMG_W), .IDX_W(COL_W)) u_l2 (
    .clk     (clk),
    .col     (col_q),
    .wr_en   (proc),
    .wr_data (l1_rd),
    .rd_data (l2_rd)
  );

`ifdef LBP_FETCH_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (state_q != ST_DONE && stall && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_lbp_window_fetch.sv
// Directed bench for lbp_window_fetch: ramp frame with stall and gray_ready
// gap, post-done idle, mid-frame reset, and a random-backpressure frame.
module tb_lbp_window_fetch;

  localparam int W    = 128;
  localparam int H    = 128;
  localparam int AW   = 14;
  localparam int NWIN = (W-2)*(H-2);

  logic          clk = 1'b0;
  logic          reset;
  logic          gray_ready;
  logic          gray_req;
  logic [AW-1:0] gray_addr;
  logic [7:0]    gray_data = 8'h00;
  logic          win_valid;
  logic          win_ready;
  logic [71:0]   win_data;
  logic [AW-1:0] win_addr;
  logic          done;
`ifdef LBP_FETCH_PERF_EN
  logic [15:0]   stall_cnt;
`endif

  logic [7:0]    mem [W*H];
  int            checks = 0;
  int            failures = 0;
  int            exp_gaddr;
  int            win_idx;
  logic          prev_hold;
  logic [71:0]   prev_data;
  logic [AW-1:0] prev_addr;

  lbp_window_fetch dut (
    .clk        (clk),
    .reset      (reset),
    .gray_ready (gray_ready),
    .gray_req   (gray_req),
    .gray_addr  (gray_addr),
    .gray_data  (gray_data),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .win_data   (win_data),
    .win_addr   (win_addr),
`ifdef LBP_FETCH_PERF_EN
    .stall_cnt  (stall_cnt),
`endif
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (gray_req) gray_data <= mem[gray_addr];
  end

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] exp_win(input int r, input int c);
    logic [71:0] v;
    v = '0;
    for (int k = 0; k < 9; k++) v[8*k +: 8] = mem[(r-1+k/3)*W + (c-1+k%3)];
    return v;
  endfunction

  task automatic check_reset_values();
    chk("rst_gray_req", gray_req, 0);
    chk("rst_gray_addr", gray_addr, 0);
    chk("rst_win_valid", win_valid, 0);
    chk("rst_win_data", win_data, 0);
    chk("rst_win_addr", win_addr, 0);
    chk("rst_done", done, 0);
`ifdef LBP_FETCH_PERF_EN
    chk("rst_stall_cnt", stall_cnt, 0);
`endif
  endtask

  // mode 0: ramp with 20-cycle stall at first window and gray_ready gap in row 5
  // mode 1: gray_ready=1, win_ready random
  task automatic run_frame(input int mode, input int stop_at);
    int  cyc = 0, budget = 0, t_req = -1, last_hs = -1;
    int  stall_left = 0, gr_low = 0;
    bit  first_seen = 0, gr_done = 0;
    int  r, c;
    exp_gaddr = 0;
    win_idx   = 0;
    prev_hold = 0;
    while (!done && win_idx < stop_at && budget < 40000) begin
      if (mode == 0) begin
        if (win_valid && !first_seen) begin
          first_seen = 1;
          chk("first_latency", cyc - t_req, 260);
          chk("first_addr", win_addr, 129);
          chk("first_data", win_data, 72'h020100828180020100);
          stall_left = 20;
        end
        if (!gr_done && exp_gaddr == 5*W + 64) begin
          gr_low  = 10;
          gr_done = 1;
        end
        gray_ready = (gr_low == 0);
        win_ready  = (stall_left == 0);
      end else begin
        gray_ready = 1'b1;
        win_ready  = 1'($urandom_range(0, 1));
      end
      #1;
      if (gray_req && t_req < 0) t_req = cyc;
      if (stall_left > 0) begin
        chk("stall_gray_req", gray_req, 0);
        chk("stall_gray_addr", gray_addr, 260);
      end
      if (gr_low > 0) chk("gap_gray_req", gray_req, 0);
      if (gray_req) begin
        chk("gray_addr", gray_addr, exp_gaddr);
        exp_gaddr++;
      end
      if (prev_hold) begin
        chk("hold_valid", win_valid, 1);
        chk("hold_data", win_data, prev_data);
        chk("hold_addr", win_addr, prev_addr);
      end
      if (win_valid && win_ready) begin
        r = win_idx / (W-2) + 1;
        c = win_idx % (W-2) + 1;
        chk("win_addr", win_addr, r*W + c);
        chk("win_data", win_data, exp_win(r, c));
        win_idx++;
        last_hs = cyc;
      end
      prev_hold = win_valid && !win_ready;
      prev_data = win_data;
      prev_addr = win_addr;
      if (failures > 20) break;
      @(negedge clk);
      cyc++;
      budget++;
      if (stall_left > 0) stall_left--;
      if (gr_low > 0) gr_low--;
    end
    chk("frame_budget", budget < 40000, 1);
    if (stop_at > NWIN) begin
      chk("win_count", win_idx, NWIN);
      chk("done", done, 1);
      chk("last_addr", prev_addr, (H-2)*W + (W-2));
      chk("done_timing", cyc - last_hs, 1);
      chk("drain_gray_req", gray_req, 0);
    end
  endtask

  initial begin
    reset      = 1'b1;
    gray_ready = 1'b0;
    win_ready  = 1'b0;
    for (int i = 0; i < W*H; i++) mem[i] = 8'(i);
    #1;
    check_reset_values();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("idle_gray_req", gray_req, 0);
    chk("idle_win_valid", win_valid, 0);
    @(negedge clk);

    run_frame(0, NWIN + 1);
`ifdef LBP_FETCH_PERF_EN
    chk("stall_cnt", stall_cnt, 20);
`endif

    for (int i = 0; i < 20; i++) begin
      gray_ready = 1'b1;
      win_ready  = 1'(i % 2);
      #1;
      chk("post_gray_req", gray_req, 0);
      chk("post_win_valid", win_valid, 0);
      chk("post_done", done, 1);
      @(negedge clk);
    end

    reset = 1'b1;
    for (int i = 0; i < W*H; i++) mem[i] = 8'($urandom);
    @(negedge clk);
    reset = 1'b0;
    run_frame(1, 7000);
    reset = 1'b1;
    #1;
    check_reset_values();
    repeat (2) @(negedge clk);
    #1;
    check_reset_values();
    @(negedge clk);
    reset = 1'b0;
    run_frame(1, NWIN + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
